stream_rr_arbiter: RTL and testbench

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

---
 rtl/stream_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 36 +++
 rtl/stream_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared types and constants for the stream round-robin arbiter
//
// Purpose : Holds the arbiter FSM state enum and the per-requester byte width.
// Ports   : none (package)
package stream_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin next-grant search
//
// Purpose : Finds the first set request bit starting at (last_grant+1) mod
//           G_NUM_PORTS and wrapping upward; last_grant itself is checked last.
// Ports   : req_in        - request vector, one bit per requester
//           last_grant_in - index of the most recent owner
//           next_grant    - index of the winning requester (0 when none)
//           found         - at least one request bit is set
module rr_pick #(
  parameter int G_NUM_PORTS = 4,
  parameter int G_IDX_W     = 2
) (
  input  logic [G_NUM_PORTS-1:0] req_in,
  input  logic [G_IDX_W-1:0]     last_grant_in,
  output logic [G_IDX_W-1:0]     next_grant,
  output logic                   found
);

  logic [G_IDX_W-1:0] idx;

  // Walk the distances from farthest to nearest so the nearest requester
  // (distance 1 from last_grant) is the final, winning assignment.
  always_comb begin
    next_grant = '0;
    found      = 1'b0;
    idx        = '0;
    for (int k = G_NUM_PORTS; k >= 1; k--) begin
      idx = G_IDX_W'((int'(last_grant_in) + k) % G_NUM_PORTS);
      if (req_in[idx]) begin
        next_grant = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - packet-level round-robin merge of byte streams
//
// Purpose : Merges G_NUM_PORTS byte streams onto one output stream. Ownership is
//           granted per packet in round-robin order with a one-cycle arbitration
//           bubble; a packet longer than G_MAX_LEN beats is cut with a forced
//           tlast and its remainder re-arbitrated as a new packet.
// Macro   : STREAM_ARB_STATS_EN adds per-port completed-packet counters.
// Ports   : clk_in, rst_in        - clock, synchronous active-high reset
//           s_tdata_in            - requester data, port i at [8i+7:8i]
//           s_tvalid_in/s_tlast_in/s_tready_out - per-requester handshake
//           m_tdata_out/m_tvalid_out/m_tlast_out/m_tready_in - merged stream
//           grant_out/grant_vld_out - current owner index and ownership flag
//           stat_trunc_cnt        - saturating count of force-released packets
//           stat_pkt_cnt          - (STREAM_ARB_STATS_EN) per-port packet counts
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int G_NUM_PORTS = 4,
  parameter int G_MAX_LEN   = 256
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [G_NUM_PORTS*BYTE_W-1:0]   s_tdata_in,
  input  logic [G_NUM_PORTS-1:0]          s_tvalid_in,
  input  logic [G_NUM_PORTS-1:0]          s_tlast_in,
  output logic [G_NUM_PORTS-1:0]          s_tready_out,
  output logic [BYTE_W-1:0]               m_tdata_out,
  output logic                            m_tvalid_out,
  output logic                            m_tlast_out,
  input  logic                            m_tready_in,
  output logic [$clog2(G_NUM_PORTS)-1:0]  grant_out,
  output logic                            grant_vld_out,
  output logic [15:0]                     stat_trunc_cnt
`ifdef STREAM_ARB_STATS_EN
  ,
  output logic [G_NUM_PORTS*16-1:0]       stat_pkt_cnt
`endif
);

  localparam int GW = $clog2(G_NUM_PORTS);
  localparam int CW = $clog2(G_MAX_LEN + 1);

  arb_state_t     state;
  logic [GW-1:0]  grant;
  logic [GW-1:0]  last_grant;
  logic [CW-1:0]  beat_cnt;
  logic [15:0]    trunc_cnt;

  logic [GW-1:0]  pick_grant;
  logic           pick_found;

  logic           in_xfer;
  logic           sel_valid;
  logic           sel_last;
  logic           at_max;
  logic           hs;
  logic           release_beat;
  logic           forced;

  rr_pick #(
    .G_NUM_PORTS (G_NUM_PORTS),
    .G_IDX_W     (GW)
  ) u_rr_pick (
    .req_in        (s_tvalid_in),
    .last_grant_in (last_grant),
    .next_grant    (pick_grant),
    .found         (pick_found)
  );

  // Datapath is a pure mux from the owner; m_tvalid_out never looks at m_tready_in.
  assign in_xfer      = (state == S_XFER);
  assign sel_valid    = s_tvalid_in[grant];
  assign sel_last     = s_tlast_in[grant];
  // beat_cnt counts completed beats, so the G_MAX_LEN-th beat sees G_MAX_LEN-1.
  assign at_max       = (beat_cnt == CW'(G_MAX_LEN - 1));
  assign m_tdata_out  = s_tdata_in[grant*BYTE_W +: BYTE_W];
  assign m_tvalid_out = in_xfer & sel_valid;
  assign m_tlast_out  = in_xfer & (sel_last | at_max);
  assign hs           = m_tvalid_out & m_tready_in;
  assign release_beat = sel_last | at_max;
  assign forced       = at_max & ~sel_last;

  assign grant_out      = grant;
  assign grant_vld_out  = in_xfer;
  assign stat_trunc_cnt = trunc_cnt;

  always_comb begin
    s_tready_out = '0;
    if (in_xfer) begin
      s_tready_out[grant] = m_tready_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= GW'(G_NUM_PORTS - 1);
      beat_cnt   <= '0;
      trunc_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant    <= pick_grant;
            beat_cnt <= '0;
            state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (hs) begin
            if (release_beat) begin
              last_grant <= grant;
              state      <= S_IDLE;
              if (forced && (trunc_cnt != 16'hFFFF)) begin
                trunc_cnt <= trunc_cnt + 16'd1;
              end
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef STREAM_ARB_STATS_EN
  logic [15:0] pkt_cnt [G_NUM_PORTS];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < G_NUM_PORTS; i++) begin
        pkt_cnt[i] <= '0;
      end
    end else if (hs && release_beat && (pkt_cnt[grant] != 16'hFFFF)) begin
      pkt_cnt[grant] <= pkt_cnt[grant] + 16'd1;
    end
  end

  always_comb begin
    stat_pkt_cnt = '0;
    for (int i = 0; i < G_NUM_PORTS; i++) begin
      stat_pkt_cnt[i*16 +: 16] = pkt_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - randomized scoreboard bench for stream_rr_arbiter
module tb_stream_rr_arbiter;

  localparam int N    = 4;
  localparam int MAXL = 4;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic [N*8-1:0] s_tdata_in;
  logic [N-1:0]   s_tvalid_in;
  logic [N-1:0]   s_tlast_in;
  logic [N-1:0]   s_tready_out;
  logic [7:0]     m_tdata_out;
  logic           m_tvalid_out;
  logic           m_tlast_out;
  logic           m_tready_in;
  logic [1:0]     grant_out;
  logic           grant_vld_out;
  logic [15:0]    stat_trunc_cnt;
`ifdef STREAM_ARB_STATS_EN
  logic [N*16-1:0] stat_pkt_cnt;
`endif

  always #5 clk_in = ~clk_in;

  stream_rr_arbiter #(
    .G_NUM_PORTS (N),
    .G_MAX_LEN   (MAXL)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .s_tdata_in     (s_tdata_in),
    .s_tvalid_in    (s_tvalid_in),
    .s_tlast_in     (s_tlast_in),
    .s_tready_out   (s_tready_out),
    .m_tdata_out    (m_tdata_out),
    .m_tvalid_out   (m_tvalid_out),
    .m_tlast_out    (m_tlast_out),
    .m_tready_in    (m_tready_in),
    .grant_out      (grant_out),
    .grant_vld_out  (grant_vld_out),
    .stat_trunc_cnt (stat_trunc_cnt)
`ifdef STREAM_ARB_STATS_EN
    ,
    .stat_pkt_cnt   (stat_pkt_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic            valid;
    logic            gvld;
    logic [1:0]      grant;
    logic [N-1:0]    rdy;
    logic [15:0]     trunc;
    logic [N*16-1:0] pkt;
  } cyc_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } src_t;

  beat_t exp_beats[$];
  cyc_t  exp_cyc[$];
  src_t  src_q [N][$];

  // Reference model state: packet-level ownership bookkeeping.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_beats;
  int m_trunc;
  int m_pkt [N];

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
    m_beats = 0;
    m_trunc = 0;
    for (int i = 0; i < N; i++) m_pkt[i] = 0;
  endtask

  task automatic refill(input int max_len);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() == 0 && $urandom_range(0, 2) == 0) begin
        int len;
        len = $urandom_range(1, max_len);
        for (int b = 1; b <= len; b++) begin
          src_t s;
          s.data = 8'($urandom);
          s.last = (b == len);
          src_q[i].push_back(s);
        end
      end
    end
  endtask

  // One cycle: drive inputs, record what the arbiter must show this cycle,
  // then advance the model (and the sources) past the coming clock edge.
  task automatic step(input bit do_rst, input int vprob, input int rprob);
    logic [N-1:0]   vin;
    logic [N-1:0]   lin;
    logic [N*8-1:0] din;
    logic           rdy;
    cyc_t           c;
    vin = '0;
    lin = '0;
    din = '0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && $urandom_range(0, 99) < vprob) begin
        vin[i]       = 1'b1;
        lin[i]       = src_q[i][0].last;
        din[i*8 +: 8] = src_q[i][0].data;
      end
    end
    rdy = ($urandom_range(0, 99) < rprob);
    rst_in      = do_rst;
    s_tvalid_in = vin;
    s_tlast_in  = lin;
    s_tdata_in  = din;
    m_tready_in = rdy;

    c.valid = m_busy && vin[m_owner];
    c.gvld  = m_busy;
    c.grant = m_busy ? 2'(m_owner) : 2'd0;
    c.rdy   = m_busy ? (N'(rdy) << m_owner) : '0;
    c.trunc = 16'(m_trunc);
    for (int i = 0; i < N; i++) c.pkt[i*16 +: 16] = 16'(m_pkt[i]);
    exp_cyc.push_back(c);

    if (m_busy) begin
      if (vin[m_owner] && rdy) begin
        beat_t b;
        bit    rel;
        m_beats++;
        rel    = lin[m_owner] || (m_beats == MAXL);
        b.port = 2'(m_owner);
        b.data = din[m_owner*8 +: 8];
        b.last = rel;
        exp_beats.push_back(b);
        void'(src_q[m_owner].pop_front());
        if (rel) begin
          if (!lin[m_owner] && m_trunc < 65535) m_trunc++;
          if (m_pkt[m_owner] < 65535) m_pkt[m_owner]++;
          m_last = m_owner;
          m_busy = 1'b0;
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!m_busy && vin[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_busy  = 1'b1;
          m_beats = 0;
        end
      end
    end
    if (do_rst) model_reset();
  endtask

  always @(negedge clk_in) begin
    if (mon_en) begin
      if (exp_cyc.size() == 0) begin
        check("cycle_queue_underflow", 64'd1, 64'd0);
      end else begin
        cyc_t c;
        c = exp_cyc.pop_front();
        check("m_tvalid", 64'(m_tvalid_out), 64'(c.valid));
        check("grant_vld", 64'(grant_vld_out), 64'(c.gvld));
        if (c.gvld) check("grant", 64'(grant_out), 64'(c.grant));
        check("s_tready", 64'(s_tready_out), 64'(c.rdy));
        check("trunc_cnt", 64'(stat_trunc_cnt), 64'(c.trunc));
`ifdef STREAM_ARB_STATS_EN
        check("pkt_cnt", 64'(stat_pkt_cnt), 64'(c.pkt));
`endif
      end
      if (m_tvalid_out && m_tready_in) begin
        if (exp_beats.size() == 0) begin
          check("unexpected_beat", 64'(m_tdata_out), 64'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = exp_beats.pop_front();
          check("beat_port", 64'(grant_out), 64'(b.port));
          check("beat_data", 64'(m_tdata_out), 64'(b.data));
          check("beat_last", 64'(m_tlast_out), 64'(b.last));
        end
      end
    end
  end

  initial begin
    int rst_events;
    rst_events  = 0;
    rst_in      = 1'b1;
    s_tdata_in  = '0;
    s_tvalid_in = '0;
    s_tlast_in  = '0;
    m_tready_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    check("reset_m_tvalid", 64'(m_tvalid_out), 64'd0);
    check("reset_s_tready", 64'(s_tready_out), 64'd0);
    check("reset_grant_vld", 64'(grant_vld_out), 64'd0);
    check("reset_grant", 64'(grant_out), 64'd0);
    check("reset_trunc", 64'(stat_trunc_cnt), 64'd0);
`ifdef STREAM_ARB_STATS_EN
    check("reset_pkt_cnt", 64'(stat_pkt_cnt), 64'd0);
`endif
    mon_en = 1'b1;

    // Fairness: every port always offers single-beat packets.
    for (int it = 0; it < 300; it++) begin
      refill(1);
      step(1'b0, 100, 100);
      @(posedge clk_in);
      #1;
    end
    // Mixed lengths (some beyond MAXL), random gaps and backpressure, with
    // resets landing mid-packet.
    for (int it = 0; it < 1500; it++) begin
      bit r;
      refill(7);
      r = (rst_events < 3) && (it >= 400 * (rst_events + 1)) && m_busy && (m_beats >= 1);
      if (r) rst_events++;
      step(r, 70, 50);
      @(posedge clk_in);
      #1;
    end
    // Saturated long packets.
    for (int it = 0; it < 500; it++) begin
      refill(9);
      step(1'b0, 100, 100);
      @(posedge clk_in);
      #1;
    end
    // Drain: sources finish, nothing new is generated.
    for (int it = 0; it < 200; it++) begin
      step(1'b0, 100, 100);
      @(posedge clk_in);
      #1;
    end
    mon_en = 1'b0;
    check("reset_events", 64'(rst_events), 64'd3);
    check("beats_left", 64'(exp_beats.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
